mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage of the pipelined MIPS core.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request per start pulse and models the fixed operation latency with a countdown.
- Commits results to the architectural HI/LO registers and drives busy, which the hazard unit uses to stall MFHI/MFLO and further MDU instructions.

Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU to HI/LO update (must be >=1)
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU to HI/LO update (must be >=1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- start  input  1  request valid for one cycle; sampled only when busy=0
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- src_a  input  32  rs operand
- src_b  input  32  rt operand
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse in the cycle HI/LO are updated by a MULT/DIV op
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, pending regs=0; overrides everything, including an op in flight.
- States: IDLE, RUN.
- IDLE, start=1, op=MULT/MULTU:
  - Compute the 64-bit product (signed or unsigned) into pending_hi/pending_lo.
  - counter=MULT_CYCLES-1; busy=1 from the next cycle; go to RUN.
- IDLE, start=1, op=DIV/DIVU:
  - pending_lo=quotient, pending_hi=remainder.
  - Signed ops truncate toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
  - src_b==0: pending regs = current hi/lo, so HI/LO are left unchanged on commit.
  - counter=DIV_CYCLES-1; go to RUN.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) = src_a at the next edge; busy stays 0; no done pulse.
- IDLE, start=1, op=NONE or reserved: no effect.
- RUN:
  - Counter decrements each cycle.
  - In the cycle counter==0: hi/lo = pending values at the edge, done=1 for that following cycle, busy=0, state=IDLE.
  - Total latency = N cycles after the accept edge, where N is MULT_CYCLES or DIV_CYCLES.
- start while busy=1: ignored, never queued. The stall logic guarantees it does not happen; the bench checks that it is ignored.
- hi/lo hold their old values throughout RUN. Reads during RUN are stalled externally, so stale values are never consumed.
- A new start is accepted in the cycle after done asserts (busy already 0): back-to-back throughput is 1 op per N+1 cycles.
- Operands are sampled only at the accept edge; later changes on src_a/src_b have no effect.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- When defined, an extra input cancel (1 bit) is added for exception/flush of the EX-stage instruction.
  - cancel=1 in RUN: return to IDLE at the next edge, busy=0, done=0; hi/lo keep their pre-op values and pending values are discarded.
  - cancel=1 in IDLE suppresses an accompanying start, including MTHI/MTLO.
  - cancel has priority over completion in the same cycle.
- When not defined: no cancel port; an op in flight always completes, and only reset aborts it.

Decomposition:
- Shared package (mdu_pkg):
  - op encodings MDU_NONE..MDU_MTLO as 3-bit localparams
  - state encodings ST_IDLE/ST_RUN
  - default latency constants
- One natural sub-module, mdu_arith: combinational 64-bit multiply and div/rem with signedness and divide-by-zero/overflow rules. mdu_ctrl owns the FSM, counter, pending and HI/LO registers.

Test Plan:
- MULT, src_a=0xFFFFFFFE (-2), src_b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse once.
- MULTU, 0xFFFFFFFF*0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV, -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 with prior hi=0x11, lo=0x22 -> HI/LO unchanged, done still pulses.
- MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never rises; start=1 MTLO during a DIV RUN -> lo unaffected.
- reset=0 at cycle 3 of a DIV -> busy=0, hi=lo=0, no done pulse afterwards.
- MDU_CANCEL_EN: MULT then cancel at cycle 2 -> busy drops, hi/lo keep prior values; cancel coincident with the final cycle -> no commit.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU op encodings (3-bit, matches the decoder's op field)
//   - FSM state type for mdu_ctrl
//   - default operation latencies
//   - op classification helpers
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_t;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    function automatic logic isMulOp(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath for the MDU.
//   op        : MDU op code (only MULT/MULTU/DIV/DIVU produce a result)
//   srcA/srcB : rs / rt operands
//   resHi     : product[63:32] or remainder
//   resLo     : product[31:0]  or quotient
//   divByZero : srcB == 0 (caller decides what to commit)
// Signed division truncates toward zero and the remainder follows the
// dividend's sign. 0x80000000 / -1 falls out naturally as lo=0x80000000, hi=0.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] resHi,
    output logic [31:0] resLo,
    output logic        divByZero
);

    logic        signedOp;
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod;

    always_comb begin
        signedOp  = (op == MDU_MULT) || (op == MDU_DIV);
        divByZero = (srcB == '0);

        // Explicit extension so one multiplier serves both signednesses.
        if (signedOp)
            prod = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        else
            prod = {32'b0, srcA} * {32'b0, srcB};

        // Signed divide via magnitudes, then restore signs.
        negA    = signedOp & srcA[31];
        negB    = signedOp & srcB[31];
        magA    = negA ? (32'd0 - srcA) : srcA;
        magB    = negB ? (32'd0 - srcB) : srcB;
        divisor = divByZero ? 32'd1 : magB;
        quo     = magA / divisor;
        rem     = magA % divisor;

        resHi = '0;
        resLo = '0;
        if (isMulOp(op)) begin
            resHi = prod[63:32];
            resLo = prod[31:0];
        end else if (isDivOp(op)) begin
            resLo = (negA ^ negB) ? (32'd0 - quo) : quo;
            resHi = negA ? (32'd0 - rem) : rem;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the EX stage.
//   clk    : rising-edge clock
//   reset  : synchronous, active-low
//   cancel : (only with `define MDU_CANCEL_EN) flush of the EX-stage op
//   start  : request valid, sampled only when busy=0
//   op     : MDU op code (see mdu_pkg)
//   src_a  : rs operand, src_b : rt operand
//   busy   : operation in flight
//   done   : one-cycle pulse after HI/LO are updated by a MULT/DIV op
//   hi/lo  : architectural HI/LO registers
// Optional feature macro: MDU_CANCEL_EN adds the cancel input.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    mdu_state_t       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      pendingHi;
    logic [31:0]      pendingLo;

    logic [31:0]      resHi;
    logic [31:0]      resLo;
    logic             divByZero;
    logic             cancelIn;

`ifdef MDU_CANCEL_EN
    assign cancelIn = cancel;
`else
    assign cancelIn = 1'b0;
`endif

    mdu_arith uArith (
        .op        (op),
        .srcA      (src_a),
        .srcB      (src_b),
        .resHi     (resHi),
        .resLo     (resLo),
        .divByZero (divByZero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            pendingHi <= '0;
            pendingLo <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !cancelIn) begin
                        if (isMulOp(op)) begin
                            pendingHi <= resHi;
                            pendingLo <= resLo;
                            count     <= CNT_W'(MULT_CYCLES - 1);
                            busy      <= 1'b1;
                            state     <= ST_RUN;
                        end else if (isDivOp(op)) begin
                            // Divide by zero re-commits the current HI/LO.
                            pendingHi <= divByZero ? hi : resHi;
                            pendingLo <= divByZero ? lo : resLo;
                            count     <= CNT_W'(DIV_CYCLES - 1);
                            busy      <= 1'b1;
                            state     <= ST_RUN;
                        end else if (op == MDU_MTHI) begin
                            hi <= src_a;
                        end else if (op == MDU_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                ST_RUN: begin
                    // start is ignored here; cancel wins over completion.
                    if (cancelIn) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        count     <= '0;
                        pendingHi <= '0;
                        pendingLo <= '0;
                    end else if (count == '0) begin
                        hi    <= pendingHi;
                        lo    <= pendingLo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .start (start),
        .op    (op),
        .src_a (srcA),
        .src_b (srcB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: architectural result of one op given current HI/LO.
    function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] curHi,
                                             input logic [31:0] curLo);
        int    sa;
        int    sb;
        longint ps;
        sa = a;
        sb = b;
        case (o)
            3'd1: begin
                ps = longint'(sa) * longint'(sb);
                return 64'(ps);
            end
            3'd2: return 64'(a) * 64'(b);
            3'd3: begin
                if (b == 0) return {curHi, curLo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd4: begin
                if (b == 0) return {curHi, curLo};
                return {a % b, a / b};
            end
            3'd5: return {a, curLo};
            3'd6: return {curHi, a};
            default: return {curHi, curLo};
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return 5;
        if (o == 3'd3 || o == 3'd4) return 10;
        return 0;
    endfunction

    // Issue one op at the current sample point and follow it to completion,
    // leaving the bench at the sample where done should be high.
    task automatic doOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi,
                        input logic [31:0] expLo, input int lat);
        int busyCnt;
        bit held;
        bit doneEarly;
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("%s done@accept", tag), {31'b0, done}, 32'd0);
        busyCnt   = 0;
        held      = 1'b1;
        doneEarly = 1'b0;
        while (busy === 1'b1 && busyCnt < 200) begin
            busyCnt++;
            if (hi !== mHi || lo !== mLo) held = 1'b0;
            if (done !== 1'b0) doneEarly = 1'b1;
            // Operand churn and stray starts while busy must be ignored.
            srcA  = $urandom;
            srcB  = $urandom;
            op    = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
        check($sformatf("%s busy cycles", tag), 32'(busyCnt), 32'(lat));
        if (lat > 0) begin
            check($sformatf("%s hold during run", tag), {31'b0, held}, 32'd1);
            check($sformatf("%s no early done", tag), {31'b0, doneEarly}, 32'd0);
            check($sformatf("%s done pulse", tag), {31'b0, done}, 32'd1);
        end
        check($sformatf("%s hi", tag), hi, expHi);
        check($sformatf("%s lo", tag), lo, expLo);
        mHi = expHi;
        mLo = expLo;
    endtask

    initial begin
        logic [63:0] r;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          cnt;

        vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{MDU_MTHI,  32'h11,        32'h0,          32'h11,        32'hFFFF_FFFD, 0};
        vecs[4]  = '{MDU_MTLO,  32'h22,        32'h0,          32'h11,        32'h22,        0};
        vecs[5]  = '{MDU_DIVU,  32'h7,         32'h0,          32'h11,        32'h22,        10};
        vecs[6]  = '{MDU_MTHI,  32'h1234_5678, 32'h0,          32'h1234_5678, 32'h22,        0};
        vecs[7]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10};
        vecs[8]  = '{MDU_DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 10};
        vecs[9]  = '{MDU_DIVU,  32'd100,       32'd7,          32'h2,         32'hE,         10};
        vecs[10] = '{MDU_NONE,  32'h55,        32'h66,         32'h2,         32'hE,         0};
        vecs[11] = '{3'd7,      32'h55,        32'h66,         32'h2,         32'hE,         0};
        vecs[12] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         5};
        vecs[13] = '{MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3,         10};
        vecs[14] = '{MDU_DIV,   32'h0,         32'h0,          32'hFFFF_FFFF, 32'h3,         10};

        // Reset holds everything at zero even with a start presented.
        reset = 1'b0;
        start = 1'b1;
        op    = MDU_MTHI;
        srcA  = 32'hFFFF_FFFF;
        srcB  = '0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        tick();
        tick();
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();

        // Table vectors, issued back to back (each start in the done cycle).
        for (int i = 0; i < 15; i++)
            doOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].expHi, vecs[i].expLo, vecs[i].lat);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            r = refModel(ro, ra, rb, mHi, mLo);
            doOp($sformatf("rnd%0d", i), ro, ra, rb, r[63:32], r[31:0], refLatency(ro));
        end
        tick();
        check("idle done low", {31'b0, done}, 32'd0);

        // MTLO presented during a DIV run must not touch LO.
        op    = MDU_DIV;
        srcA  = 32'd100;
        srcB  = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op    = MDU_MTLO;
        srcA  = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        check("mtlo-in-run busy timeout", 32'(cnt < 50), 32'd1);
        check("mtlo-in-run lo", lo, 32'd10);
        check("mtlo-in-run hi", hi, 32'd0);
        tick();
        mHi = '0;
        mLo = 32'd10;

        // Reset in the middle of a DIV: aborts, clears, no later done.
        op    = MDU_DIV;
        srcA  = 32'd50;
        srcB  = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
            tick();
        end
        check("midrst no done", 32'(cnt), 32'd0);
        mHi = '0;
        mLo = '0;

`ifdef MDU_CANCEL_EN
        doOp("pre-cancel", MDU_MTHI, 32'hAAAA_0001, 32'h0, 32'hAAAA_0001, 32'h0, 0);
        doOp("pre-cancel2", MDU_MTLO, 32'hBBBB_0002, 32'h0, 32'hAAAA_0001, 32'hBBBB_0002, 0);
        // Cancel early in a MULT.
        op    = MDU_MULT;
        srcA  = 32'd3;
        srcB  = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", {31'b0, busy}, 32'd0);
        check("cancel done", {31'b0, done}, 32'd0);
        check("cancel hi", hi, mHi);
        check("cancel lo", lo, mLo);
        for (int i = 0; i < 8; i++) tick();
        check("cancel later done", {31'b0, done}, 32'd0);
        check("cancel later lo", lo, mLo);
        // Cancel coincident with the final run cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("lastcyc still busy", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("lastcyc busy", {31'b0, busy}, 32'd0);
        check("lastcyc done", {31'b0, done}, 32'd0);
        check("lastcyc lo", lo, mLo);
        // Cancel in IDLE suppresses MTHI.
        op     = MDU_MTHI;
        srcA   = 32'h1357_9BDF;
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("idle cancel hi", hi, mHi);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
